weight_bram_sequencer: RTL and testbench

- Controls one neuron's weight BRAM: 28 x 16-bit words, 5-bit address, memory samples on negedge CLK.
- Two phases share the single BRAM port:
  - Load: a host writes weights through a valid/ready port.
  - Run: after start, the block streams all DEPTH weights in address order to the MAC through a 2-entry output FIFO with valid/ready backpressure.
- Arbitrates the port between the two phases and emits a done pulse after the last weight is consumed.

---
 rtl/weight_bram_sequencer_if.sv | 27 ++
 rtl/weight_bram_sequencer.sv | 136 +++++++++++++
 tb/tb_weight_bram_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bram_sequencer_if.sv
// Handshake bundles for the weight BRAM sequencer: host load port and MAC weight stream.
interface weight_load_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 16
);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  modport master (output ld_valid, ld_addr, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, output ld_ready);
endinterface

interface weight_stream_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 16
);
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_index;
  logic          w_last;

  modport master (output w_valid, w_data, w_index, w_last, input w_ready);
  modport slave  (input w_valid, w_data, w_index, w_last, output w_ready);
endinterface

// File: rtl/weight_bram_sequencer.sv
// Shares one weight BRAM port between host loads (IDLE) and an in-order
// read stream to the MAC (RUN) through a 2-entry output FIFO.
module weight_bram_sequencer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic           busy,
  output logic           done,
  weight_load_if.slave   ld,
  output logic [AW-1:0]  ADDR,
  output logic [DW-1:0]  DI,
  output logic           EN,
  output logic           WE,
  input  logic [DW-1:0]  bram_do,
  weight_stream_if.master w
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] issue_cnt;
  logic          inflight;
  logic [1:0]    fifo_count;
  logic          rd_ptr, wr_ptr;
  logic [DW-1:0] fifo_data [2];
  logic [AW-1:0] fifo_idx  [2];

  logic          pop, load, issue;
  logic [2:0]    occ;
  logic          en_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] di_d;

  // Occupancy after this edge counts the read still in flight, so a third entry is never requested.
  assign pop         = w.w_valid & w.w_ready;
  assign occ         = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign load        = ld.ld_valid & ld.ld_ready;
  assign ld.ld_ready = (state == IDLE) && !start;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign w.w_valid   = (fifo_count != 2'd0);
  assign w.w_data    = fifo_data[rd_ptr];
  assign w.w_index   = fifo_idx[rd_ptr];
  assign w.w_last    = w.w_valid && (fifo_idx[rd_ptr] == AW'(DEPTH - 1));

  // Next state and next BRAM port values.
  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = ADDR;
    di_d    = DI;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else if (load) begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = ld.ld_addr;
          di_d   = ld.ld_data;
        end
      end
      RUN: begin
        issue = (issue_cnt < CW'(DEPTH)) && (occ < 3'd2);
        if (issue) begin
          en_d   = 1'b1;
          addr_d = AW'(issue_cnt);
        end
        if (pop && w.w_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // Registered BRAM port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EN   <= 1'b0;
      WE   <= 1'b0;
      ADDR <= '0;
      DI   <= '0;
    end else begin
      EN   <= en_d;
      WE   <= we_d;
      ADDR <= addr_d;
      DI   <= di_d;
    end
  end

  // Read issue counter and in-flight flag; the counter rewinds whenever not running.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issue_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (state != RUN) issue_cnt <= '0;
      else if (issue)   issue_cnt <= issue_cnt + CW'(1);
    end
  end

  // Output FIFO: the in-flight read lands here with the address it was issued on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_count <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= bram_do;
        fifo_idx[wr_ptr]  <= ADDR;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge-sampling BRAM model.
module tb_weight_bram_sequencer;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          busy, done, EN, WE;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DI;
  logic [DW-1:0] bram_do;

  weight_load_if   #(.AW(AW), .DW(DW)) ld_if ();
  weight_stream_if #(.AW(AW), .DW(DW)) w_if ();

  weight_bram_sequencer #(.DEPTH(28), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .ld(ld_if), .ADDR(ADDR), .DI(DI), .EN(EN), .WE(WE),
    .bram_do(bram_do), .w(w_if)
  );

  always #5 CLK = ~CLK;

  // BRAM model: samples on negedge.
  logic [DW-1:0] mem [32];
  always @(negedge CLK) begin
    if (EN) begin
      if (WE) mem[ADDR] <= DI;
      bram_do <= mem[ADDR];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter and stream monitor.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0] rx_data [$];
  logic [AW-1:0] rx_idx  [$];
  logic          rx_last [$];
  int            rx_cyc  [$];
  int en_run = 0, we_cnt = 0, done_cnt = 0, done_cyc = 0;
  int max_out = 0, issued = 0, popped = 0;

  always @(negedge CLK) begin
    if (RST) begin
      issued = 0;
      popped = 0;
    end else begin
      if (EN && !WE && busy) begin
        issued++;
        en_run++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (WE) we_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (w_if.w_valid && w_if.w_ready) begin
        rx_data.push_back(w_if.w_data);
        rx_idx.push_back(w_if.w_index);
        rx_last.push_back(w_if.w_last);
        rx_cyc.push_back(cyc);
        popped++;
      end
    end
  end

  // w_ready driver: 0 always ready, 1 random, 2 five-cycle stall once index 3 is at the head.
  int rdy_mode = 0;
  int bp_left  = 0;
  bit bp_done  = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (rdy_mode == 2) begin
      if (bp_left > 0) begin
        bp_left--;
        w_if.w_ready = 1'b0;
      end else if (!bp_done && w_if.w_valid && w_if.w_index == AW'(3)) begin
        bp_done = 1'b1;
        bp_left = 4;
        w_if.w_ready = 1'b0;
      end else begin
        w_if.w_ready = 1'b1;
      end
    end else begin
      bp_done = 1'b0;
      bp_left = 0;
      w_if.w_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [DW-1:0] exp_mem [28];

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 32'({EN, WE, busy, done, w_if.w_valid, w_if.w_last}), 0);
    check({tag, "_addr_idx"}, 32'({ADDR, w_if.w_index}), 0);
    check({tag, "_di"}, 32'(DI), 0);
  endtask

  // Called and returns at posedge+1.
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_addr  = a;
    ld_if.ld_data  = d;
    @(posedge CLK);
    #1;
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic start_run(output int s);
    start = 1'b1;
    @(posedge CLK);
    #1;
    s = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!done && t < 400);
    check({tag, "_done_seen"}, 32'(done), 1);
  endtask

  task automatic verify_run(input string tag, input int base, input int en0,
                            input int done0, input int s, input bit timing);
    int n;
    repeat (3) @(negedge CLK);
    #1;
    n = rx_data.size() - base;
    check({tag, "_done_once"}, 32'(done_cnt - done0), 1);
    check({tag, "_en_count"}, 32'(en_run - en0), 28);
    check({tag, "_rx_count"}, 32'(n), 28);
    check({tag, "_idle_after"}, 32'({busy, ld_if.ld_ready}), 32'b01);
    if (n == 28) begin
      for (int i = 0; i < 28; i++) begin
        check({tag, "_index"}, 32'(rx_idx[base+i]), 32'(i));
        check({tag, "_data"}, 32'(rx_data[base+i]), 32'(exp_mem[i]));
        check({tag, "_last"}, 32'(rx_last[base+i]), 32'(i == 27));
      end
      check({tag, "_done_latency"}, 32'(done_cyc - rx_cyc[base+27]), 1);
      if (timing) begin
        check({tag, "_first_latency"}, 32'(rx_cyc[base] - s), 2);
        check({tag, "_back_to_back"}, 32'(rx_cyc[base+27] - rx_cyc[base]), 27);
      end
    end
  endtask

  task automatic do_run(input string tag, input int mode);
    int base, en0, done0, s;
    base  = rx_data.size();
    en0   = en_run;
    done0 = done_cnt;
    rdy_mode = mode;
    start_run(s);
    @(negedge CLK);
    check({tag, "_busy"}, 32'({busy, ld_if.ld_ready}), 32'b10);
    wait_done(tag);
    verify_run(tag, base, en0, done0, s, mode == 0);
    rdy_mode = 0;
  endtask

  task automatic bp_checks();
    int t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(w_if.w_valid && w_if.w_index == AW'(3)) && t < 200);
    check("bp_reach_idx3", 32'(t < 200), 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_head_idx", 32'(w_if.w_index), 3);
      check("bp_head_data", 32'(w_if.w_data), 32'h0103);
      check("bp_head_valid", 32'(w_if.w_valid), 1);
      if (k < 4) @(negedge CLK);
    end
    check("bp_no_issue_full", 32'(EN), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base, en0, done0, we0, s, t;
    RST = 1'b1;
    start = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_addr  = '0;
    ld_if.ld_data  = '0;
    #23;
    check_reset("rst_held");
    #4;
    RST = 1'b0;
    #1;
    check_reset("rst_released");
    check("idle_ld_ready", 32'(ld_if.ld_ready), 1);

    // Load 0..27 then stream at full rate.
    @(posedge CLK);
    #1;
    for (int i = 0; i < 28; i++) begin
      load(AW'(i), DW'(16'h0100 + i));
      exp_mem[i] = DW'(16'h0100 + i);
    end
    do_run("t1", 0);

    // Backpressure on index 3.
    @(posedge CLK);
    #1;
    fork
      do_run("t2", 2);
      bp_checks();
    join
    check("t2_max_outstanding", 32'(max_out), 2);

    // Random w_ready.
    @(posedge CLK);
    #1;
    do_run("t3", 1);

    // start and ld_valid together: start wins, load waits for IDLE.
    @(posedge CLK);
    #1;
    base = rx_data.size();
    en0 = en_run;
    done0 = done_cnt;
    we0 = we_cnt;
    start = 1'b1;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_addr  = AW'(7);
    ld_if.ld_data  = 16'hDEAD;
    @(negedge CLK);
    check("t4_ready_low_on_start", 32'(ld_if.ld_ready), 0);
    @(posedge CLK);
    #1;
    s = cyc;
    start = 1'b0;
    @(negedge CLK);
    check("t4_ready_low_in_run", 32'({busy, ld_if.ld_ready}), 32'b10);
    wait_done("t4");
    #1;
    check("t4_no_write_in_run", 32'(we_cnt - we0), 0);
    check("t4_ready_low_in_done", 32'(ld_if.ld_ready), 0);
    @(negedge CLK);
    check("t4_ready_in_idle", 32'(ld_if.ld_ready), 1);
    @(posedge CLK);
    #1;
    ld_if.ld_valid = 1'b0;
    @(negedge CLK);
    check("t4_load_en_we", 32'({EN, WE}), 32'b11);
    check("t4_load_addr", 32'(ADDR), 7);
    check("t4_load_data", 32'(DI), 32'hDEAD);
    verify_run("t4", base, en0, done0, s, 1'b1);
    exp_mem[7] = 16'hDEAD;

    // Reset in the middle of a run, then a clean restart.
    @(posedge CLK);
    #1;
    base = rx_data.size();
    start_run(s);
    t = 0;
    do begin
      @(negedge CLK);
      #1;
      t++;
    end while (rx_data.size() < base + 10 && t < 200);
    check("t5_reached_10th", 32'(rx_data.size() - base), 10);
    RST = 1'b1;
    #1;
    check_reset("t5_rst");
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    do_run("t5_restart", 0);

    // Write right before start, read back in that run.
    @(posedge CLK);
    #1;
    load(AW'(5), 16'hBEEF);
    exp_mem[5] = 16'hBEEF;
    do_run("t6", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
